// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a DEPTH x 8-bit register file. Latency: 2-flop bus sync, strobes one cycle after detection.
// Backpressure: none by default; `I2C_SLAVE_CLK_STRETCH_EN holds SCL low STRETCH_CYC clocks after each ACK slot.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         DEPTH       = 16,
  parameter int         STRETCH_CYC = 8,
  localparam int        PTR_W       = $clog2(DEPTH)
) (
  input  logic             i2c_core_clk_i,
  input  logic             i2c_core_rst_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic             scl_oe_o,
  output logic             start_o,
  output logic             stop_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic [PTR_W-1:0] ptr_o,
  output logic             busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t     state, state_nxt;
  logic       scl_m, scl_s, scl_d, sda_m, sda_s, sda_d;
  logic       start_det, stop_det, scl_rise, scl_fall;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, tx_sh;
  logic       rw, mst_nack;
  logic [7:0] regs [DEPTH];

  logic shift_en, ack_smp, cnt_clr, ack_on, ack_off, ptr_load, ptr_inc, wr_en;
  logic rd_load, rd_drive, tx_next, tx_rel;

  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      {scl_m, scl_s, scl_d} <= 3'b111;
      {sda_m, sda_s, sda_d} <= 3'b111;
    end else begin
      {scl_m, scl_s, scl_d} <= {scl_i, scl_m, scl_s};
      {sda_m, sda_s, sda_d} <= {sda_i, sda_m, sda_s};
    end
  end

  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;

  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    ack_smp   = 1'b0;
    cnt_clr   = 1'b0;
    ack_on    = 1'b0;
    ack_off   = 1'b0;
    ptr_load  = 1'b0;
    ptr_inc   = 1'b0;
    wr_en     = 1'b0;
    rd_load   = 1'b0;
    tx_next   = 1'b0;
    tx_rel    = 1'b0;
    // START wins over everything, including a coincident SCL edge
    if (start_det) begin
      state_nxt = ADDR;
      cnt_clr   = 1'b1;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else if (scl_rise) begin
      shift_en = (state == ADDR) || (state == PTR) || (state == WR_DATA) || (state == RD_DATA);
      ack_smp  = (state == RD_ACK);
    end else if (scl_fall) begin
      case (state)
        ADDR: if (bit_cnt == 4'd8) begin
          if (shreg[7:1] == SLAVE_ADDR) begin
            state_nxt = ADDR_ACK;
            ack_on    = 1'b1;
          end else begin
            state_nxt = IGNORE;
          end
        end
        ADDR_ACK: begin
          ack_off = 1'b1;
          cnt_clr = 1'b1;
          if (rw) begin
            state_nxt = RD_DATA;
            rd_load   = 1'b1;
          end else begin
            state_nxt = PTR;
          end
        end
        PTR: if (bit_cnt == 4'd8) begin
          state_nxt = PTR_ACK;
          ack_on    = 1'b1;
          ptr_load  = 1'b1;
        end
        PTR_ACK: begin
          state_nxt = WR_DATA;
          ack_off   = 1'b1;
          cnt_clr   = 1'b1;
        end
        WR_DATA: if (bit_cnt == 4'd8) begin
          state_nxt = WR_ACK;
          ack_on    = 1'b1;
          wr_en     = 1'b1;
        end
        WR_ACK: begin
          state_nxt = WR_DATA;
          ack_off   = 1'b1;
          cnt_clr   = 1'b1;
          ptr_inc   = 1'b1;
        end
        RD_DATA: begin
          if (bit_cnt == 4'd8) begin
            state_nxt = RD_ACK;
            tx_rel    = 1'b1;
            ptr_inc   = 1'b1;
          end else if (bit_cnt != 4'd0) begin
            tx_next = 1'b1;
          end
        end
        RD_ACK: begin
          cnt_clr = 1'b1;
          if (mst_nack) begin
            state_nxt = IGNORE;
          end else begin
            state_nxt = RD_DATA;
            rd_load   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic [7:0] stretch_cnt;
  logic       tx_pend, slot_end;

  assign slot_end = scl_fall & ~start_det & ~stop_det &
                    ((state == ADDR_ACK) || (state == PTR_ACK) || (state == WR_ACK) || (state == RD_ACK));
  // next read bit goes out on the same edge that lets SCL go
  assign rd_drive = tx_pend && (stretch_cnt == 8'd1);
  assign scl_oe_o = (stretch_cnt != 8'd0);

  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      stretch_cnt <= 8'd0;
      tx_pend     <= 1'b0;
    end else begin
      if (slot_end)                 stretch_cnt <= 8'(STRETCH_CYC);
      else if (stretch_cnt != 8'd0) stretch_cnt <= stretch_cnt - 8'd1;
      if (start_det || stop_det) tx_pend <= 1'b0;
      else if (rd_load)          tx_pend <= 1'b1;
      else if (rd_drive)         tx_pend <= 1'b0;
    end
  end
`else
  assign rd_drive = rd_load;
  assign scl_oe_o = 1'b0;
`endif

  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      tx_sh      <= 8'h00;
      rw         <= 1'b0;
      mst_nack   <= 1'b1;
      sda_oe_o   <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      ptr_o      <= '0;
      busy_o     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      start_o    <= start_det;
      stop_o     <= stop_det;
      rx_valid_o <= 1'b0;
      if (start_det)     busy_o <= 1'b1;
      else if (stop_det) busy_o <= 1'b0;

      if (cnt_clr) begin
        bit_cnt <= 4'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= {shreg[6:0], sda_s};
      end
      if (ack_smp) mst_nack <= sda_s;
      if (ack_on && state == ADDR) rw <= shreg[0];

      if (wr_en) begin
        regs[ptr_o] <= shreg;
        rx_data_o   <= shreg;
        rx_valid_o  <= 1'b1;
      end
      if (ptr_load)     ptr_o <= shreg[PTR_W-1:0];
      else if (ptr_inc) ptr_o <= ptr_o + PTR_W'(1);

      if (start_det || stop_det) begin
        sda_oe_o <= 1'b0;
      end else if (ack_on) begin
        sda_oe_o <= 1'b1;
      end else if (rd_drive) begin
        sda_oe_o <= ~regs[ptr_o][7];
        tx_sh    <= {regs[ptr_o][6:0], 1'b0};
      end else if (ack_off || tx_rel) begin
        sda_oe_o <= 1'b0;
      end else if (tx_next) begin
        sda_oe_o <= ~tx_sh[7];
        tx_sh    <= {tx_sh[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed I2C master driving i2c_slave_regfile (SLAVE_ADDR 0x50, DEPTH 16) with hand-computed expectations.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_bus, sda_bus;
  logic       sda_oe_o, scl_oe_o, start_o, stop_o, rx_valid_o, busy_o;
  logic [7:0] rx_data_o;
  logic [3:0] ptr_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_stop   = 0;
  int n_rxv    = 0;
  int n_sdaoe  = 0;
  int n_scloe  = 0;
  int run      = 0;
  int n_runs   = 0;
  int bad_runs = 0;

  always #5 clk = ~clk;

  assign scl_bus = scl_m & ~scl_oe_o;
  assign sda_bus = sda_m & ~sda_oe_o;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .DEPTH(16), .STRETCH_CYC(8)) dut (
    .i2c_core_clk_i (clk),
    .i2c_core_rst_i (rst),
    .scl_i          (scl_bus),
    .sda_i          (sda_bus),
    .sda_oe_o       (sda_oe_o),
    .scl_oe_o       (scl_oe_o),
    .start_o        (start_o),
    .stop_o         (stop_o),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .ptr_o          (ptr_o),
    .busy_o         (busy_o)
  );

  always @(posedge clk) begin
    if (start_o)    n_start++;
    if (stop_o)     n_stop++;
    if (rx_valid_o) n_rxv++;
    if (sda_oe_o)   n_sdaoe++;
    if (scl_oe_o)   n_scloe++;
    if (scl_oe_o) begin
      run++;
    end else if (run != 0) begin
      n_runs++;
      if (run != 8) bad_runs++;
      run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_up();
    int n = 0;
    scl_m = 1'b1;
    while (scl_bus !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("scl_release", 32'(scl_bus), 32'h1);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    q_wait();
    scl_up();
    q_wait();
    sda_m = 1'b0;
    q_wait();
    scl_m = 1'b0;
    q_wait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    q_wait();
    scl_up();
    q_wait();
    sda_m = 1'b1;
    q_wait();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      q_wait();
      scl_up();
      q_wait();
      scl_m = 1'b0;
      q_wait();
    end
    sda_m = 1'b1;
    q_wait();
    scl_up();
    q_wait();
    ack = sda_bus;
    scl_m = 1'b0;
    q_wait();
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    b = 8'h00;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q_wait();
      scl_up();
      q_wait();
      b = {b[6:0], sda_bus};
      scl_m = 1'b0;
    end
    q_wait();
    sda_m = nack;
    q_wait();
    scl_up();
    q_wait();
    scl_m = 1'b0;
    q_wait();
    sda_m = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] pb;
    int s0, p0, r0, o0;

    // reset state
    repeat (4) @(negedge clk);
    check("rst_strobes", 32'({sda_oe_o, scl_oe_o, start_o, stop_o, rx_valid_o, busy_o}), 32'h0);
    check("rst_rx_data", 32'(rx_data_o), 32'h00);
    check("rst_ptr", 32'(ptr_o), 32'h0);
    rst = 1'b0;
    q_wait();

    // write ptr 3, data 0x5A
    s0 = n_start; p0 = n_stop; r0 = n_rxv;
    i2c_start();
    check("t1_busy", 32'(busy_o), 32'h1);
    wr_byte(8'hA0, ack); check("t1_ack_addr", 32'(ack), 32'h0);
    wr_byte(8'h03, ack); check("t1_ack_ptr", 32'(ack), 32'h0);
    wr_byte(8'h5A, ack); check("t1_ack_data", 32'(ack), 32'h0);
    i2c_stop();
    check("t1_rx_data", 32'(rx_data_o), 32'h5A);
    check("t1_rx_valid_pulses", 32'(n_rxv - r0), 32'h1);
    check("t1_ptr", 32'(ptr_o), 32'h4);
    check("t1_busy_after_stop", 32'(busy_o), 32'h0);
    check("t1_start_pulses", 32'(n_start - s0), 32'h1);
    check("t1_stop_pulses", 32'(n_stop - p0), 32'h1);

    // reg[4] = 0xC3
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h04, ack);
    wr_byte(8'hC3, ack); check("t1b_ack_data", 32'(ack), 32'h0);
    i2c_stop();
    check("t1b_ptr", 32'(ptr_o), 32'h5);

    // ptr 3, repeated START, read two bytes, NACK, then ignored until STOP
    s0 = n_start; r0 = n_rxv;
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h03, ack);
    i2c_start();
    wr_byte(8'hA1, ack); check("t2_ack_rd_addr", 32'(ack), 32'h0);
    rd_byte(1'b0, d); check("t2_rd0", 32'(d), 32'h5A);
    rd_byte(1'b1, d); check("t2_rd1", 32'(d), 32'hC3);
    check("t2_start_pulses", 32'(n_start - s0), 32'h2);
    o0 = n_sdaoe;
    wr_byte(8'hA0, ack); check("t2_ignore_noack", 32'(ack), 32'h1);
    check("t2_ignore_sda_free", 32'(n_sdaoe - o0), 32'h0);
    check("t2_busy_ignore", 32'(busy_o), 32'h1);
    i2c_stop();
    check("t2_ptr", 32'(ptr_o), 32'h5);
    check("t2_no_rx_valid", 32'(n_rxv - r0), 32'h0);

    // pointer wrap at DEPTH
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h0F, ack);
    wr_byte(8'h11, ack); check("t3_ack_d0", 32'(ack), 32'h0);
    wr_byte(8'h22, ack); check("t3_ack_d1", 32'(ack), 32'h0);
    i2c_stop();
    check("t3_ptr_wrap", 32'(ptr_o), 32'h1);
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h0F, ack);
    i2c_start();
    wr_byte(8'hA1, ack);
    rd_byte(1'b0, d); check("t3_reg15", 32'(d), 32'h11);
    rd_byte(1'b1, d); check("t3_reg0", 32'(d), 32'h22);
    i2c_stop();
    check("t3_ptr_after_rd", 32'(ptr_o), 32'h1);

    // read without a pointer phase uses the retained pointer
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h0E, ack);
    wr_byte(8'h77, ack);
    i2c_stop();
    i2c_start();
    wr_byte(8'hA1, ack); check("t3b_ack", 32'(ack), 32'h0);
    rd_byte(1'b1, d); check("t3b_retained_rd", 32'(d), 32'h11);
    i2c_stop();
    check("t3b_ptr", 32'(ptr_o), 32'h0);

    // foreign address
    r0 = n_rxv; o0 = n_sdaoe;
    i2c_start();
    wr_byte(8'hA2, ack); check("t4_nack_addr", 32'(ack), 32'h1);
    check("t4_busy", 32'(busy_o), 32'h1);
    wr_byte(8'h55, ack); check("t4_nack_data", 32'(ack), 32'h1);
    i2c_stop();
    check("t4_busy_after_stop", 32'(busy_o), 32'h0);
    check("t4_no_rx_valid", 32'(n_rxv - r0), 32'h0);
    check("t4_sda_never_driven", 32'(n_sdaoe - o0), 32'h0);

    // reset during bit 4 of a data byte
    pb = 8'h99;
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h02, ack);
    for (int i = 7; i >= 4; i--) begin
      sda_m = pb[i];
      q_wait();
      scl_up();
      if (i > 4) begin
        q_wait();
        scl_m = 1'b0;
        q_wait();
      end
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_rst_strobes", 32'({sda_oe_o, scl_oe_o, start_o, stop_o, rx_valid_o, busy_o}), 32'h0);
    check("t5_rst_rx_data", 32'(rx_data_o), 32'h00);
    check("t5_rst_ptr", 32'(ptr_o), 32'h0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q_wait();
    r0 = n_rxv;
    i2c_start();
    wr_byte(8'hA0, ack); check("t5_ack_addr", 32'(ack), 32'h0);
    wr_byte(8'h06, ack); check("t5_ack_ptr", 32'(ack), 32'h0);
    wr_byte(8'h3C, ack); check("t5_ack_data", 32'(ack), 32'h0);
    i2c_stop();
    check("t5_rx_data", 32'(rx_data_o), 32'h3C);
    check("t5_rx_valid_pulses", 32'(n_rxv - r0), 32'h1);
    check("t5_ptr", 32'(ptr_o), 32'h7);
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h03, ack);
    i2c_start();
    wr_byte(8'hA1, ack);
    rd_byte(1'b1, d); check("t5_reg3_cleared", 32'(d), 32'h00);
    i2c_stop();
    check("t5_ptr_after_rd", 32'(ptr_o), 32'h4);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    check("stretch_runs_seen", 32'(n_runs > 0), 32'h1);
    check("stretch_run_len", 32'(bad_runs), 32'h0);
`else
    check("scl_oe_never", 32'(n_scloe), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
